// File: rtl/keypad_pkg.sv
// Shared types and sizes for the scanned 4x4 keypad reader.
// No logic here; consumed by keypad_scan and its interface.
// No flow control; pure definitions.
package keypad_pkg;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int KEY_W    = 4;

  // Key-qualification state machine.
  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD
  } state_e;

  // Outcome of one whole scan frame.
  typedef enum logic [1:0] {
    NONE,
    ONE,
    MULTI
  } frame_res_e;
endpackage

// File: rtl/keypad_scan_if.sv
// Pin-side bundle of the keypad reader: column strobes, row sense, key events.
// Wires only, no latency.
// No backpressure; key events are single-cycle pulses plus a held level.
interface keypad_scan_if;
  import keypad_pkg::*;

  logic [NUM_COLS-1:0] o_col;
  logic [NUM_ROWS-1:0] i_row;
  logic [KEY_W-1:0]    o_key;
  logic                o_key_valid;
  logic                o_key_held;
  logic                o_key_release;

  // Keypad reader side.
  modport master (
    output o_col,
    output o_key,
    output o_key_valid,
    output o_key_held,
    output o_key_release,
    input  i_row
  );

  // Board pins / consumer side.
  modport slave (
    input  o_col,
    input  o_key,
    input  o_key_valid,
    input  o_key_held,
    input  o_key_release,
    output i_row
  );
endinterface

// File: rtl/scan_tick_gen.sv
// Column dwell timer: counts SCAN_DIV cycles per column and walks the column index.
// tick_o is combinational from the count; col_idx_o advances on the tick edge.
// Free-running, no stall input.
module scan_tick_gen #(
  parameter int SCAN_DIV = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       tick_o,
  output logic [1:0] col_idx_o
);
  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       col_q, col_d;

  assign tick_o    = (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign col_idx_o = col_q;

  // Next dwell count and column; column index wraps 3 -> 0 naturally.
  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + CNT_W'(1);
    col_d = tick_o ? col_q + 2'd1 : col_q;
  end

  // Dwell counter and column index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      col_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      col_q <= col_d;
    end
  end
endmodule

// File: rtl/keypad_scan.sv
// Scanned 4x4 keypad reader: strobes columns, qualifies one key over whole frames.
// Press/release reported one cycle after the qualifying frame-end edge.
// No backpressure; valid/release are fire-and-forget single-cycle pulses.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 5000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  keypad_scan_if.master kp
);
  localparam logic [3:0] DS = 4'(DEBOUNCE_SCANS);

  logic       tick;
  logic [1:0] col_idx;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_o    (tick),
    .col_idx_o (col_idx)
  );

  logic [NUM_ROWS-1:0] row_meta_q, row_sync_q;
  logic [NUM_COLS-1:0] col_drv_q;
  logic [1:0]          acc_hits_q;
  logic [KEY_W-1:0]    acc_code_q;
  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [KEY_W-1:0]    cand_q, cand_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic                valid_q, valid_d;
  logic                held_q, held_d;
  logic                release_q, release_d;

  logic [1:0]       col_hits;
  logic [1:0]       row_idx;
  logic [2:0]       hit_sum;
  logic [1:0]       frame_hits;
  logic [KEY_W-1:0] frame_code;
  logic             frame_end;
  frame_res_e       frame_res;

  // Two-flop synchronizer on the asynchronous row inputs; idle rows read high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
    end else begin
      row_meta_q <= kp.i_row;
      row_sync_q <= row_meta_q;
    end
  end

  // Registered one-cold column drive, moved to the next column on each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) col_drv_q <= 4'b1110;
    else if (tick) col_drv_q <= ~(4'b0001 << (col_idx + 2'd1));
  end

  // Hits in the current column (saturating at 2) and the lowest low row.
  always_comb begin
    col_hits = '0;
    row_idx  = '0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (!row_sync_q[r]) begin
        row_idx = 2'(r);
        if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
      end
    end
  end

  // Fold this column into the running frame total; the first hit fixes the code.
  always_comb begin
    hit_sum    = {1'b0, acc_hits_q} + {1'b0, col_hits};
    frame_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    frame_code = (acc_hits_q == 2'd0) ? {row_idx, col_idx} : acc_code_q;
    frame_end  = tick && (col_idx == 2'd3);
    frame_res  = (frame_hits == 2'd0) ? NONE : ((frame_hits == 2'd1) ? ONE : MULTI);
  end

  // Frame accumulator: updated on every sample, cleared as the FSM consumes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hits_q <= '0;
      acc_code_q <= '0;
    end else if (frame_end) begin
      acc_hits_q <= '0;
      acc_code_q <= '0;
    end else if (tick) begin
      acc_hits_q <= frame_hits;
      acc_code_q <= frame_code;
    end
  end

  // Qualification FSM, evaluated only when a frame completes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    key_d     = key_q;
    held_d    = held_q;
    valid_d   = 1'b0;
    release_d = 1'b0;
    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (frame_res == ONE) begin
            cand_d = frame_code;
            if (DS == 4'd1) begin
              key_d   = frame_code;
              valid_d = 1'b1;
              held_d  = 1'b1;
              cnt_d   = '0;
              state_d = HELD;
            end else begin
              cnt_d   = 4'd1;
              state_d = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (frame_res == ONE && frame_code == cand_q) begin
            if (cnt_q + 4'd1 == DS) begin
              key_d   = cand_q;
              valid_d = 1'b1;
              held_d  = 1'b1;
              cnt_d   = '0;
              state_d = HELD;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        HELD: begin
          if (frame_res == NONE) begin
            if (cnt_q + 4'd1 == DS) begin
              release_d = 1'b1;
              held_d    = 1'b0;
              cnt_d     = '0;
              state_d   = IDLE;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // FSM state and registered key outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cand_q    <= '0;
      key_q     <= '0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      key_q     <= key_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
      release_q <= release_d;
    end
  end

  assign kp.o_col         = col_drv_q;
  assign kp.o_key         = key_q;
  assign kp.o_key_valid   = valid_q;
  assign kp.o_key_held    = held_q;
  assign kp.o_key_release = release_q;
endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a keypad matrix model on the pins, frame-level reference model.
module tb_keypad_scan;
  localparam int SCAN_DIV = 8;
  localparam int DS       = 3;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pressed = '0;   // bit r*4+c = key at row r, column c = key code
  logic [3:0]  row_v;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  keypad_scan_if kp_if ();

  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp_if)
  );

  always #5 clk = ~clk;

  // Matrix: a row reads low when any pressed key in it sits on a driven column.
  always_comb begin
    row_v = '1;
    for (int r = 0; r < 4; r++) row_v[r] = ~|(pressed[r*4 +: 4] & ~kp_if.o_col);
  end
  assign kp_if.i_row = row_v;

  // Observations gathered over one frame.
  int         obs_nvalid, obs_vpos, obs_nrel, obs_rpos, obs_both, obs_colerr;
  logic [3:0] obs_key;
  logic       obs_held;

  // Reference model state (frame granularity).
  bit         m_held;
  logic [3:0] m_key;
  logic [3:0] m_cand;
  int         m_run, m_rrun;

  task automatic model_reset();
    m_held = 0; m_key = '0; m_cand = '0; m_run = 0; m_rrun = 0;
  endtask

  // One frame of key set 'keys': 0 keys = nothing, 1 key = candidate, more = ambiguous.
  task automatic model_frame(input logic [15:0] keys, output bit ev, output bit er);
    int n;
    int idx;
    n = $countones(keys);
    idx = 0;
    for (int b = 15; b >= 0; b--) if (keys[b]) idx = b;
    ev = 0; er = 0;
    if (!m_held) begin
      if (m_run > 0) begin
        if (n == 1 && idx == int'(m_cand)) m_run++;
        else m_run = 0;
      end else if (n == 1) begin
        m_cand = 4'(idx);
        m_run = 1;
      end
      if (m_run == DS) begin
        ev = 1; m_key = m_cand; m_held = 1; m_run = 0; m_rrun = 0;
      end
    end else begin
      if (n == 0) m_rrun++;
      else m_rrun = 0;
      if (m_rrun == DS) begin
        er = 1; m_held = 0; m_rrun = 0;
      end
    end
  endtask

  // Apply a key set for exactly one frame and record what the DUT did.
  task automatic run_frame(input logic [15:0] keys);
    logic [3:0] one;
    logic [3:0] ecol;
    one = 4'b0001;
    pressed = keys;
    obs_nvalid = 0; obs_vpos = 0; obs_nrel = 0; obs_rpos = 0; obs_both = 0; obs_colerr = 0;
    for (int i = 1; i <= FRAME; i++) begin
      @(posedge clk);
      #1;
      ecol = ~(one << ((i / SCAN_DIV) % 4));
      if (kp_if.o_col !== ecol) obs_colerr++;
      if (kp_if.o_key_valid === 1'b1) begin obs_nvalid++; obs_vpos = i; end
      if (kp_if.o_key_release === 1'b1) begin obs_nrel++; obs_rpos = i; end
      if (kp_if.o_key_valid === 1'b1 && kp_if.o_key_release === 1'b1) obs_both++;
    end
    obs_key  = kp_if.o_key;
    obs_held = kp_if.o_key_held;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (kp_if.o_col !== 4'b1110) begin n_fail++; $display("FAIL reset_col: got %b, expected 1110", kp_if.o_col); end
    n_checks++; if (kp_if.o_key !== 4'd0) begin n_fail++; $display("FAIL reset_key: got %h, expected 0", kp_if.o_key); end
    n_checks++; if (kp_if.o_key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", kp_if.o_key_valid); end
    n_checks++; if (kp_if.o_key_held !== 1'b0) begin n_fail++; $display("FAIL reset_held: got %b, expected 0", kp_if.o_key_held); end
    n_checks++; if (kp_if.o_key_release !== 1'b0) begin n_fail++; $display("FAIL reset_release: got %b, expected 0", kp_if.o_key_release); end
    rst_n = 1'b1;
  endtask

  task automatic test_scan_idle();
    for (int f = 0; f < 3; f++) begin
      run_frame('0);
      n_checks++; if (obs_colerr != 0) begin n_fail++; $display("FAIL idle_col frame %0d: %0d bad column cycles, expected 0", f, obs_colerr); end
      n_checks++; if (obs_nvalid != 0 || obs_nrel != 0) begin n_fail++; $display("FAIL idle_pulse frame %0d: valid=%0d release=%0d, expected 0/0", f, obs_nvalid, obs_nrel); end
      n_checks++; if (obs_held !== 1'b0 || obs_key !== 4'd0) begin n_fail++; $display("FAIL idle_key frame %0d: held=%b key=%h, expected 0/0", f, obs_held, obs_key); end
    end
  endtask

  task automatic test_press_release();
    bit ev, er;
    int vf, rf;
    vf = -1; rf = -1;
    for (int f = 0; f < 14; f++) begin
      logic [15:0] k;
      k = (f < 10) ? 16'h0200 : 16'h0000;
      run_frame(k);
      model_frame(k, ev, er);
      if (obs_nvalid > 0) vf = f;
      if (obs_nrel > 0) rf = f;
      n_checks++; if (obs_nvalid != int'(ev) || (ev && obs_vpos != FRAME)) begin n_fail++; $display("FAIL pr_valid frame %0d: pulses=%0d at %0d, expected %0d at %0d", f, obs_nvalid, obs_vpos, ev, FRAME); end
      n_checks++; if (obs_nrel != int'(er) || (er && obs_rpos != FRAME)) begin n_fail++; $display("FAIL pr_release frame %0d: pulses=%0d at %0d, expected %0d at %0d", f, obs_nrel, obs_rpos, er, FRAME); end
      n_checks++; if (obs_held !== m_held || obs_key !== m_key) begin n_fail++; $display("FAIL pr_state frame %0d: held=%b key=%h, expected %b %h", f, obs_held, obs_key, m_held, m_key); end
      n_checks++; if (obs_colerr != 0 || obs_both != 0) begin n_fail++; $display("FAIL pr_misc frame %0d: colerr=%0d overlap=%0d, expected 0/0", f, obs_colerr, obs_both); end
    end
    n_checks++; if (vf != 2 || rf != 12) begin n_fail++; $display("FAIL pr_timing: valid frame %0d release frame %0d, expected 2 and 12", vf, rf); end
  endtask

  task automatic test_bounce();
    bit ev, er;
    int nv, vf;
    logic [15:0] tbl [11];
    tbl = '{16'h8000, 16'h0000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
            16'h0000, 16'h0000, 16'h0000, 16'h0000};
    nv = 0; vf = -1;
    for (int f = 0; f < 11; f++) begin
      run_frame(tbl[f]);
      model_frame(tbl[f], ev, er);
      nv += obs_nvalid;
      if (obs_nvalid > 0) vf = f;
      n_checks++; if (obs_nvalid != int'(ev) || (ev && obs_vpos != FRAME)) begin n_fail++; $display("FAIL bounce_valid frame %0d: pulses=%0d at %0d, expected %0d", f, obs_nvalid, obs_vpos, ev); end
      n_checks++; if (obs_nrel != int'(er)) begin n_fail++; $display("FAIL bounce_release frame %0d: pulses=%0d, expected %0d", f, obs_nrel, er); end
      n_checks++; if (obs_held !== m_held || obs_key !== m_key) begin n_fail++; $display("FAIL bounce_state frame %0d: held=%b key=%h, expected %b %h", f, obs_held, obs_key, m_held, m_key); end
    end
    n_checks++; if (nv != 1 || vf != 4) begin n_fail++; $display("FAIL bounce_once: %0d valids, last at frame %0d, expected 1 at frame 4", nv, vf); end
  endtask

  task automatic test_multi();
    bit ev, er;
    for (int f = 0; f < 7; f++) begin
      logic [15:0] k;
      k = (f < 6) ? 16'h0005 : 16'h0000;
      run_frame(k);
      model_frame(k, ev, er);
      n_checks++; if (obs_nvalid != 0 || obs_held !== 1'b0) begin n_fail++; $display("FAIL multi frame %0d: valid=%0d held=%b, expected 0/0", f, obs_nvalid, obs_held); end
      n_checks++; if (obs_nvalid != int'(ev) || obs_nrel != int'(er) || obs_key !== m_key) begin n_fail++; $display("FAIL multi_model frame %0d: valid=%0d rel=%0d key=%h, expected %0d %0d %h", f, obs_nvalid, obs_nrel, obs_key, ev, er, m_key); end
    end
  endtask

  task automatic test_second_key();
    bit ev, er;
    int nv, nr;
    nv = 0; nr = 0;
    for (int f = 0; f < 12; f++) begin
      logic [15:0] k;
      k = (f < 4) ? 16'h0200 : ((f < 8) ? 16'h0210 : 16'h0000);
      run_frame(k);
      model_frame(k, ev, er);
      nv += obs_nvalid; nr += obs_nrel;
      n_checks++; if (obs_nvalid != int'(ev) || obs_nrel != int'(er)) begin n_fail++; $display("FAIL second_pulses frame %0d: valid=%0d rel=%0d, expected %0d %0d", f, obs_nvalid, obs_nrel, ev, er); end
      n_checks++; if (obs_key !== m_key || obs_held !== m_held) begin n_fail++; $display("FAIL second_state frame %0d: key=%h held=%b, expected %h %b", f, obs_key, obs_held, m_key, m_held); end
    end
    n_checks++; if (nv != 1 || nr != 1 || obs_key !== 4'd9) begin n_fail++; $display("FAIL second_total: valids=%0d releases=%0d key=%h, expected 1 1 9", nv, nr, obs_key); end
  endtask

  task automatic test_reset_mid();
    bit ev, er;
    int vf;
    for (int f = 0; f < 2; f++) begin
      run_frame(16'h0040);
      model_frame(16'h0040, ev, er);
      n_checks++; if (obs_nvalid != 0 || obs_held !== 1'b0) begin n_fail++; $display("FAIL rmid_pre frame %0d: valid=%0d held=%b, expected 0/0", f, obs_nvalid, obs_held); end
    end
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (kp_if.o_col !== 4'b1110 || kp_if.o_key !== 4'd0) begin n_fail++; $display("FAIL rmid_async: col=%b key=%h, expected 1110 0", kp_if.o_col, kp_if.o_key); end
    n_checks++; if (kp_if.o_key_valid !== 1'b0 || kp_if.o_key_held !== 1'b0 || kp_if.o_key_release !== 1'b0) begin n_fail++; $display("FAIL rmid_flags: v=%b h=%b r=%b, expected 0 0 0", kp_if.o_key_valid, kp_if.o_key_held, kp_if.o_key_release); end
    model_reset();
    release_reset();
    vf = -1;
    for (int f = 0; f < 7; f++) begin
      logic [15:0] k;
      k = (f < 4) ? 16'h0040 : 16'h0000;
      run_frame(k);
      model_frame(k, ev, er);
      if (obs_nvalid > 0) vf = f;
      n_checks++; if (obs_nvalid != int'(ev) || obs_nrel != int'(er)) begin n_fail++; $display("FAIL rmid_pulses frame %0d: valid=%0d rel=%0d, expected %0d %0d", f, obs_nvalid, obs_nrel, ev, er); end
      n_checks++; if (obs_key !== m_key || obs_held !== m_held) begin n_fail++; $display("FAIL rmid_state frame %0d: key=%h held=%b, expected %h %b", f, obs_key, obs_held, m_key, m_held); end
    end
    n_checks++; if (vf != 2) begin n_fail++; $display("FAIL rmid_latency: valid at frame %0d after reset, expected 2", vf); end
  endtask

  task automatic test_random();
    bit ev, er;
    logic [15:0] k;
    k = 16'h0001 << $urandom_range(0, 15);
    for (int f = 0; f < 44; f++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (f >= 40) k = '0;
      else if (sel == 6 || sel == 7) k = '0;
      else if (sel == 8) k = 16'h0001 << $urandom_range(0, 15);
      else if (sel == 9) k = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      run_frame(k);
      model_frame(k, ev, er);
      n_checks++; if (obs_nvalid != int'(ev) || (ev && obs_vpos != FRAME)) begin n_fail++; $display("FAIL rnd_valid frame %0d keys %h: pulses=%0d at %0d, expected %0d", f, k, obs_nvalid, obs_vpos, ev); end
      n_checks++; if (obs_nrel != int'(er) || (er && obs_rpos != FRAME)) begin n_fail++; $display("FAIL rnd_release frame %0d keys %h: pulses=%0d at %0d, expected %0d", f, k, obs_nrel, obs_rpos, er); end
      n_checks++; if (obs_key !== m_key || obs_held !== m_held) begin n_fail++; $display("FAIL rnd_state frame %0d keys %h: key=%h held=%b, expected %h %b", f, k, obs_key, obs_held, m_key, m_held); end
      n_checks++; if (obs_colerr != 0 || obs_both != 0) begin n_fail++; $display("FAIL rnd_misc frame %0d: colerr=%0d overlap=%0d, expected 0/0", f, obs_colerr, obs_both); end
    end
  endtask

  initial begin
    test_reset();
    test_scan_idle();
    test_press_release();
    test_bounce();
    test_multi();
    test_second_key();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
